// File: rtl/byte_serializer.sv
// MSB-first word serializer with an upstream release handshake and a frame counter.
// Optional even-parity trailer bit is built when SERIALIZER_PARITY_EN is defined.
module byte_serializer #(
   parameter int unsigned FIFO_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] data_i,
   input  logic                  data_rd,
   input  logic                  shift_en,
   output logic                  data_use,
   output logic                  ser_o,
   output logic                  ser_valid,
   output logic                  ser_last,
   output logic                  busy,
   output logic [7:0]            frame_cnt
);

   localparam int unsigned W     = FIFO_WIDTH;
   localparam int unsigned CNT_W = (W > 2) ? $clog2(W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic             data_use_q, data_use_d;
   logic             ser_o_q, ser_o_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_last_q, ser_last_d;
   logic             busy_q, busy_d;
`ifdef SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      data_use_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_d       = par_q;
`endif

      case (state_q)
         IDLE: begin
            if (data_rd) begin
               sreg_d     = data_i;
               cnt_d      = '0;
               data_use_d = 1'b1;
               state_d    = SHIFT;
`ifdef SERIALIZER_PARITY_EN
               par_d      = ^data_i;
`endif
            end
         end
         SHIFT: begin
            if (shift_en) begin
               sreg_d = {sreg_q[W-2:0], 1'b0};
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d     = IDLE;
                  frame_cnt_d = frame_cnt_q + 8'd1;
`endif
               end
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            if (shift_en) begin
               state_d     = IDLE;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // Outputs are registered from next-state so they line up with the state they describe
      busy_d      = (state_d != IDLE);
      ser_valid_d = (state_d != IDLE);
      ser_o_d     = (state_d == SHIFT) && sreg_d[W-1];
      ser_last_d  = (state_d == SHIFT) && (cnt_d == LAST_BIT);
`ifdef SERIALIZER_PARITY_EN
      ser_o_d     = ser_o_d || ((state_d == PARITY) && par_d);
      ser_last_d  = (state_d == PARITY);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
         data_use_q  <= 1'b0;
         ser_o_q     <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         data_use_q  <= data_use_d;
         ser_o_q     <= ser_o_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
         busy_q      <= busy_d;
`ifdef SERIALIZER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign data_use  = data_use_q;
   assign ser_o     = ser_o_q;
   assign ser_valid = ser_valid_q;
   assign ser_last  = ser_last_q;
   assign busy      = busy_q;
   assign frame_cnt = frame_cnt_q;

endmodule
